// File: rtl/reg_dest_tracker_pkg.sv
// Shared encodings for the register-destination tracker.
// Destination-select codes and default special-register indices.
package reg_dest_tracker_pkg;

  localparam logic [2:0] SEL_RT = 3'd0;
  localparam logic [2:0] SEL_RS = 3'd1;
  localparam logic [2:0] SEL_SP = 3'd2;
  localparam logic [2:0] SEL_RA = 3'd3;
  localparam logic [2:0] SEL_RD = 3'd4;

  localparam int SP_IDX_DEF = 29;
  localparam int RA_IDX_DEF = 31;

  function automatic logic sel_legal(
    input logic [2:0] sel
  );
    return sel <= SEL_RD;
  endfunction

endpackage

// File: rtl/reg_dest_fifo.sv
// In-order circular FIFO of pending register writes.
// Ports: push/pop/din in; mem, valid mask, rd_ptr, count out.
module reg_dest_fifo #(
  parameter int AW    = 5,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [AW-1:0]              din,
  output logic [DEPTH-1:0][AW-1:0]   mem,
  output logic [DEPTH-1:0]           valid,
  output logic [$clog2(DEPTH)-1:0]   rd_ptr,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] off;
  logic          pop_eff;

  // A pop on an empty FIFO is dropped here.
  assign pop_eff = pop && (count != '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop_eff) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count + CW'(push) - CW'(pop_eff);
    end
  end

  // Slot i is live when its distance from the head is below count.
  always_comb begin
    valid = '0;
    off   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off      = PW'(i) - rd_ptr;
      valid[i] = {1'b0, off} < count;
    end
  end

endmodule

// File: rtl/reg_dest_tracker.sv
// Destination-register decode plus pending-writeback hazard tracker.
// Ports: select/fields in, dest out, issue/retire FIFO, hazards, errors.
module reg_dest_tracker
  import reg_dest_tracker_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int DEPTH  = 4,
  parameter int SP_IDX = SP_IDX_DEF,
  parameter int RA_IDX = RA_IDX_DEF
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [2:0]               reg_dest,
  input  logic [REG_AW-1:0]        rt,
  input  logic [REG_AW-1:0]        rs,
  input  logic [REG_AW-1:0]        rd,
  output logic [REG_AW-1:0]        dest_out,
  output logic [REG_AW-1:0]        dest_q,
  input  logic                     issue_valid,
  output logic                     issue_ready,
  input  logic                     retire,
  output logic                     wb_pending,
  output logic [REG_AW-1:0]        wb_dest,
  output logic [$clog2(DEPTH):0]   count,
  input  logic [REG_AW-1:0]        chk_a,
  input  logic [REG_AW-1:0]        chk_b,
  output logic                     hazard_a,
  output logic                     hazard_b,
  output logic                     sel_err,
  output logic                     underflow_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic                          legal;
  logic                          push;
  logic [DEPTH-1:0][REG_AW-1:0]  mem;
  logic [DEPTH-1:0]              valid;
  logic [PW-1:0]                 rd_ptr;

  assign legal = sel_legal(reg_dest);

  always_comb begin
    dest_out = '0;
    unique case (1'b1)
      reg_dest == SEL_RT: dest_out = rt;
      reg_dest == SEL_RS: dest_out = rs;
      reg_dest == SEL_SP: dest_out = REG_AW'(SP_IDX);
      reg_dest == SEL_RA: dest_out = REG_AW'(RA_IDX);
      reg_dest == SEL_RD: dest_out = rd;
      default:            dest_out = '0;
    endcase
  end

  // A full FIFO still accepts when the head retires this cycle.
  assign issue_ready = legal && ((count < FULL) || retire);
  assign push        = issue_valid && issue_ready;

  reg_dest_fifo #(
    .AW    (REG_AW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (retire),
    .din     (dest_out),
    .mem     (mem),
    .valid   (valid),
    .rd_ptr  (rd_ptr),
    .count   (count)
  );

  assign wb_pending = count != '0;
  assign wb_dest    = wb_pending ? mem[rd_ptr] : '0;

  // Compare against registered entries only; index 0 never hazards.
  always_comb begin
    hazard_a = 1'b0;
    hazard_b = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] && (mem[i] == chk_a)) hazard_a = 1'b1;
      if (valid[i] && (mem[i] == chk_b)) hazard_b = 1'b1;
    end
    if (chk_a == '0) hazard_a = 1'b0;
    if (chk_b == '0) hazard_b = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dest_q        <= '0;
      sel_err       <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      dest_q  <= dest_out;
      sel_err <= issue_valid && !legal;
      if (retire && !wb_pending) begin
        underflow_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_reg_dest_tracker.sv
// Directed bench for reg_dest_tracker.
// Decode table plus FIFO, hazard, error and async-reset sequences.
module tb_reg_dest_tracker;

  logic       clk;
  logic       reset_n;
  logic [2:0] reg_dest;
  logic [4:0] rt, rs, rd;
  logic [4:0] dest_out, dest_q;
  logic       issue_valid, issue_ready;
  logic       retire;
  logic       wb_pending;
  logic [4:0] wb_dest;
  logic [2:0] count;
  logic [4:0] chk_a, chk_b;
  logic       hazard_a, hazard_b;
  logic       sel_err, underflow_err;

  int checks = 0;
  int errors = 0;

  reg_dest_tracker #(
    .REG_AW (5),
    .DEPTH  (4),
    .SP_IDX (29),
    .RA_IDX (31)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .reg_dest      (reg_dest),
    .rt            (rt),
    .rs            (rs),
    .rd            (rd),
    .dest_out      (dest_out),
    .dest_q        (dest_q),
    .issue_valid   (issue_valid),
    .issue_ready   (issue_ready),
    .retire        (retire),
    .wb_pending    (wb_pending),
    .wb_dest       (wb_dest),
    .count         (count),
    .chk_a         (chk_a),
    .chk_b         (chk_b),
    .hazard_a      (hazard_a),
    .hazard_b      (hazard_b),
    .sel_err       (sel_err),
    .underflow_err (underflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] sel;
    logic [4:0] exp_dest;
    logic       exp_ready;
  } dec_vec_t;

  dec_vec_t dec_tab[8];
  int       q[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] v, input logic ret);
    reg_dest    = 3'd4;
    rd          = v;
    issue_valid = 1'b1;
    retire      = ret;
    step();
    issue_valid = 1'b0;
    retire      = 1'b0;
  endtask

  initial begin
    dec_tab[0] = '{3'd0, 5'd8,  1'b1};
    dec_tab[1] = '{3'd1, 5'd9,  1'b1};
    dec_tab[2] = '{3'd2, 5'd29, 1'b1};
    dec_tab[3] = '{3'd3, 5'd31, 1'b1};
    dec_tab[4] = '{3'd4, 5'd10, 1'b1};
    dec_tab[5] = '{3'd5, 5'd0,  1'b0};
    dec_tab[6] = '{3'd6, 5'd0,  1'b0};
    dec_tab[7] = '{3'd7, 5'd0,  1'b0};

    reset_n     = 1'b0;
    reg_dest    = 3'd0;
    rt          = 5'd8;
    rs          = 5'd9;
    rd          = 5'd10;
    issue_valid = 1'b0;
    retire      = 1'b0;
    chk_a       = 5'd0;
    chk_b       = 5'd0;

    #12;
    chk("rst_count", count, 0);
    chk("rst_pending", wb_pending, 0);
    chk("rst_wb_dest", wb_dest, 0);
    chk("rst_dest_q", dest_q, 0);
    chk("rst_sel_err", sel_err, 0);
    chk("rst_underflow", underflow_err, 0);
    chk("rst_ready", issue_ready, 1);
    reset_n = 1'b1;
    step();

    // Decode table
    foreach (dec_tab[i]) begin
      reg_dest = dec_tab[i].sel;
      #1;
      chk($sformatf("dest_out[%0d]", i), dest_out, dec_tab[i].exp_dest);
      chk($sformatf("ready[%0d]", i), issue_ready, dec_tab[i].exp_ready);
      step();
      chk($sformatf("dest_q[%0d]", i), dest_q, dec_tab[i].exp_dest);
    end

    // Fill to DEPTH, then push while retiring on a full FIFO
    issue(5'd12, 1'b0);
    issue(5'd13, 1'b0);
    issue(5'd14, 1'b0);
    issue(5'd15, 1'b0);
    chk("full_count", count, 4);
    chk("full_ready", issue_ready, 0);
    chk("full_head", wb_dest, 12);
    reg_dest    = 3'd4;
    rd          = 5'd16;
    issue_valid = 1'b1;
    retire      = 1'b1;
    #1;
    chk("full_ready_ret", issue_ready, 1);
    step();
    issue_valid = 1'b0;
    retire      = 1'b0;
    chk("fullpp_head", wb_dest, 13);
    chk("fullpp_count", count, 4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("drain_head%0d", k), wb_dest, 13 + k);
      retire = 1'b1;
      step();
      retire = 1'b0;
    end
    chk("drain_pending", wb_pending, 0);
    chk("drain_count", count, 0);

    // Hazards: pushed entry does not flag in its push cycle
    chk_a       = 5'd12;
    chk_b       = 5'd0;
    reg_dest    = 3'd4;
    rd          = 5'd12;
    issue_valid = 1'b1;
    #1;
    chk("haz_push_cycle", hazard_a, 0);
    step();
    issue_valid = 1'b0;
    issue(5'd0, 1'b0);
    chk("haz_a_set", hazard_a, 1);
    chk("haz_b_zero_idx", hazard_b, 0);
    chk_b  = 5'd13;
    #1;
    chk("haz_b_absent", hazard_b, 0);
    retire = 1'b1;
    #1;
    chk("haz_retiring", hazard_a, 1);
    step();
    chk("haz_a_after1", hazard_a, 0);
    step();
    retire = 1'b0;
    chk("haz_a_after2", hazard_a, 0);
    chk("haz_b_after2", hazard_b, 0);
    chk("haz_pending", wb_pending, 0);

    // Illegal select pulse
    reg_dest    = 3'd6;
    issue_valid = 1'b1;
    step();
    issue_valid = 1'b0;
    reg_dest    = 3'd4;
    chk("sel_err_pulse", sel_err, 1);
    chk("sel_err_nopush", count, 0);
    step();
    chk("sel_err_clear", sel_err, 0);

    // Underflow is sticky
    chk("uf_before", underflow_err, 0);
    retire = 1'b1;
    step();
    retire = 1'b0;
    chk("uf_set", underflow_err, 1);
    chk("uf_count", count, 0);
    step();
    step();
    chk("uf_held", underflow_err, 1);

    // Push and pop on empty: entry stored
    issue(5'd7, 1'b1);
    chk("pp_empty_count", count, 1);
    chk("pp_empty_head", wb_dest, 7);
    retire = 1'b1;
    step();
    retire = 1'b0;
    chk("pp_empty_drain", count, 0);

    // Wrap-around order with interleaved push/pop
    q.delete();
    issue(5'd20, 1'b0);
    q.push_back(20);
    issue(5'd21, 1'b0);
    q.push_back(21);
    for (int k = 2; k < 10; k++) begin
      issue(5'(20 + k), 1'b1);
      void'(q.pop_front());
      q.push_back(20 + k);
      chk($sformatf("wrap_head%0d", k), wb_dest, q[0]);
      chk($sformatf("wrap_count%0d", k), count, 2);
    end
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("wrap_drain%0d", k), wb_dest, q[0]);
      void'(q.pop_front());
      retire = 1'b1;
      step();
      retire = 1'b0;
    end
    chk("wrap_empty", wb_pending, 0);

    // Async reset with three entries pending
    issue(5'd5, 1'b0);
    issue(5'd6, 1'b0);
    issue(5'd7, 1'b0);
    chk_a = 5'd6;
    chk_b = 5'd7;
    #1;
    chk("pre_rst_count", count, 3);
    chk("pre_rst_haz", hazard_a, 1);
    #1;
    reset_n = 1'b0;
    #1;
    chk("arst_count", count, 0);
    chk("arst_pending", wb_pending, 0);
    chk("arst_haz_a", hazard_a, 0);
    chk("arst_haz_b", hazard_b, 0);
    chk("arst_underflow", underflow_err, 0);
    #10;
    reset_n = 1'b1;
    step();
    chk("post_rst_count", count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
